prf_int_wb_arbiter: RTL

Write-back arbiter for the integer physical register file. It collects register-write requests from NUM_REQ functional-unit result buses and packs up to PRF_INT_WAYS of them per cycle onto the PRF write ports (rd_index/rd_data/rd_en), using a registered output stage. A rotating round-robin priority keeps any unit from starving. It sits between the execute-stage result buses and the integer PRF.

---
 rtl/prf_int_pkg.sv | 41 ++++
 rtl/prf_int_rr_select.sv | 63 ++++++
 rtl/prf_int_wb_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/prf_int_pkg.sv
// ============================================================================
// Module      : prf_int_pkg
// Description : Shared types and constants for the integer PRF write-back
//               path. Supplies defaults for PRF_INT_WAYS / PRF_INT_INDEX_SIZE
//               when the build does not define them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PRF_INT_WAYS
`define PRF_INT_WAYS 4
`endif

`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

package prf_int_pkg;

   localparam int INDEX_SIZE = `PRF_INT_INDEX_SIZE;

   typedef logic [INDEX_SIZE-1:0] prf_idx_t;
   typedef logic [31:0]           word_t;

   typedef struct packed {
      logic     valid;
      prf_idx_t index;
      word_t    data;
   } wb_req_t;

   // Physical register 0 reads as zero; writes to it are dropped.
   localparam prf_idx_t PREG_ZERO = '0;

   // Index width for a pool of n entries, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : prf_int_pkg

`default_nettype wire

// File: rtl/prf_int_rr_select.sv
// ============================================================================
// Module      : prf_int_rr_select
// Description : Combinational circular priority picker. Scans requesters
//               starting at ptr_i, granting valid ones until WAYS grants that
//               need a write port have been made. Grants that need no port
//               (writes to the zero register) are still granted in passing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prf_int_rr_select
   import prf_int_pkg::*;
#(
   parameter int NUM_REQ = 6,
   parameter int WAYS    = 4,
   parameter int PTR_W   = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]          valid_i,
   input  logic [NUM_REQ-1:0]          port_req_i,
   input  logic [PTR_W-1:0]            ptr_i,
   output logic [NUM_REQ-1:0]          grant_o,
   output logic [WAYS-1:0]             way_used_o,
   output logic [WAYS-1:0][PTR_W-1:0]  way_src_o,
   output logic [PTR_W-1:0]            last_o,
   output logic                        any_grant_o
);

   localparam int WSEL_W = clog2_min1(WAYS);

   // Walk the requesters once in circular order from the pointer.
   always_comb begin
      int used;
      int idx;
      grant_o     = '0;
      way_used_o  = '0;
      way_src_o   = '0;
      last_o      = '0;
      any_grant_o = 1'b0;
      used        = 0;
      idx         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         // Once every port is taken the scan stops granting, even for
         // zero-register requests further along.
         if (valid_i[PTR_W'(idx)] && (used < WAYS)) begin
            grant_o[PTR_W'(idx)] = 1'b1;
            any_grant_o          = 1'b1;
            last_o               = PTR_W'(idx);
            if (port_req_i[PTR_W'(idx)]) begin
               way_used_o[WSEL_W'(used)] = 1'b1;
               way_src_o[WSEL_W'(used)]  = PTR_W'(idx);
               used                      = used + 1;
            end
         end
      end
   end

endmodule : prf_int_rr_select

`default_nettype wire

// File: rtl/prf_int_wb_arbiter.sv
// ============================================================================
// Module      : prf_int_wb_arbiter
// Description : Integer PRF write-back arbiter. Packs up to WAYS result-bus
//               writes per cycle onto registered PRF write ports with a
//               rotating round-robin priority.
//               Optional build macro PRF_INT_WB_PERF_EN adds saturating
//               grant and stall performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prf_int_wb_arbiter
   import prf_int_pkg::*;
#(
   parameter int NUM_REQ    = 6,
   parameter int WAYS       = `PRF_INT_WAYS,
   parameter int INDEX_SIZE = `PRF_INT_INDEX_SIZE
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic [NUM_REQ-1:0]                 req_valid_i,
   input  logic [NUM_REQ-1:0][INDEX_SIZE-1:0] req_index_i,
   input  logic [NUM_REQ-1:0][31:0]           req_data_i,
   output logic [NUM_REQ-1:0]                 req_ready_o,
   output logic [WAYS-1:0]                    rd_en_o,
   output logic [WAYS-1:0][INDEX_SIZE-1:0]    rd_index_o,
   output logic [WAYS-1:0][31:0]              rd_data_o
`ifdef PRF_INT_WB_PERF_EN
   ,
   output logic [31:0]                        perf_grants_o,
   output logic [31:0]                        perf_stalls_o
`endif
);

   localparam int PTR_W = clog2_min1(NUM_REQ);

   logic [PTR_W-1:0]           rr_ptr_q;
   logic [PTR_W-1:0]           rr_ptr_d;
   logic [WAYS-1:0]            rd_en_q;

   logic [NUM_REQ-1:0]         w_valid;
   logic [NUM_REQ-1:0]         w_port_req;
   logic [NUM_REQ-1:0]         w_grant;
   logic [WAYS-1:0]            w_way_used;
   logic [WAYS-1:0][PTR_W-1:0] w_way_src;
   logic [PTR_W-1:0]           w_last;
   logic                       w_any_grant;

   // Nothing is offered to the picker while reset is held, so no handshake
   // can complete in a reset cycle.
   assign w_valid     = reset_i ? '0 : req_valid_i;
   assign req_ready_o = w_grant;

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_port_req
         assign w_port_req[i] = (req_index_i[i] != INDEX_SIZE'(PREG_ZERO));
      end
   endgenerate

   prf_int_rr_select #(
      .NUM_REQ (NUM_REQ),
      .WAYS    (WAYS),
      .PTR_W   (PTR_W)
   ) u_select (
      .valid_i     (w_valid),
      .port_req_i  (w_port_req),
      .ptr_i       (rr_ptr_q),
      .grant_o     (w_grant),
      .way_used_o  (w_way_used),
      .way_src_o   (w_way_src),
      .last_o      (w_last),
      .any_grant_o (w_any_grant)
   );

   // Priority moves to just past the last requester served this cycle.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (w_any_grant) begin
         if (w_last == PTR_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = w_last + PTR_W'(1);
         end
      end
   end

   // Round-robin pointer and write-enable register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         rr_ptr_q <= '0;
         rd_en_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         rd_en_q  <= w_way_used;
      end
   end

   assign rd_en_o = rd_en_q;

   generate
      for (genvar w = 0; w < WAYS; w++) begin : g_way
         logic [INDEX_SIZE-1:0] index_q;
         logic [31:0]           data_q;

         // Idle ways keep their last index/data; only rd_en drops.
         always_ff @(posedge clock_i) begin
            if (reset_i) begin
               index_q <= '0;
               data_q  <= '0;
            end else if (w_way_used[w]) begin
               index_q <= req_index_i[w_way_src[w]];
               data_q  <= req_data_i[w_way_src[w]];
            end
         end

         assign rd_index_o[w] = index_q;
         assign rd_data_o[w]  = data_q;
      end
   endgenerate

`ifdef PRF_INT_WB_PERF_EN
   logic [31:0] perf_grants_q;
   logic [31:0] perf_grants_d;
   logic [31:0] perf_stalls_q;
   logic [31:0] perf_stalls_d;
   logic [32:0] w_grant_sum;
   logic        w_stall;

   // Port-consuming grants this cycle; zero-register grants are not counted.
   assign w_grant_sum = {1'b0, perf_grants_q} + 33'($countones(w_way_used));
   assign w_stall     = |(w_valid & ~w_grant);

   // Saturating next values for both counters.
   always_comb begin
      perf_grants_d = w_grant_sum[32] ? '1 : w_grant_sum[31:0];
      perf_stalls_d = perf_stalls_q;
      if (w_stall && (perf_stalls_q != '1)) begin
         perf_stalls_d = perf_stalls_q + 32'd1;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         perf_grants_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         perf_grants_q <= perf_grants_d;
         perf_stalls_q <= perf_stalls_d;
      end
   end

   assign perf_grants_o = perf_grants_q;
   assign perf_stalls_o = perf_stalls_q;
`else
   // Performance counters are not built in this configuration.
`endif

endmodule : prf_int_wb_arbiter

`default_nettype wire
